// File: rtl/qeciphy_link_supervisor.sv
// Link bring-up supervisor: pulses the PHY reset, waits for link-ready and retries on
// errors or timeouts until the retry budget runs out.
module qeciphy_link_supervisor #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       ACLK,
    input  logic       ARST,
    input  logic       enable,
    input  logic [3:0] STATUS,
    input  logic [3:0] ECODE,
    input  logic       rx_data_error,
    output logic       phy_arstn,
    output logic       traffic_en,
    output logic       link_up,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);
    localparam logic [3:0]       LINK_READY = 4'b0100;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitLink = 3'd2,
        StActive   = 3'd3,
        StFailed   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             do_retry;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        cnt_d    = cnt_q + CNT_W'(1);
        do_retry = 1'b0;

        unique case (state_q)
            StIdle: begin
                retry_d = '0;
                if (enable) state_d = StReset;
            end
            StReset: begin
                if (cnt_q == RST_LAST) state_d = StWaitLink;
            end
            StWaitLink: begin
                if (ECODE != 4'd0)              do_retry = 1'b1;
                else if (STATUS == LINK_READY)  state_d  = StActive;
                else if (cnt_q == TO_LAST)      do_retry = 1'b1;
            end
            StActive: begin
                if (ECODE != 4'd0 || STATUS != LINK_READY || rx_data_error) do_retry = 1'b1;
            end
            StFailed: begin
                state_d = StFailed;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Retry budget saturates at RETRY_MAX; exhausting it parks the FSM in FAILED.
        if (do_retry) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = StReset;
            end else begin
                state_d = StFailed;
            end
        end

        if (!enable) begin
            state_d = StIdle;
            retry_d = '0;
        end

        // The counter only runs inside RESET and WAIT_LINK and restarts on every state change.
        if (state_d != state_q || state_q == StIdle || state_q == StActive
            || state_q == StFailed) begin
            cnt_d = '0;
        end
    end

    assign phy_arstn   = (state_q == StWaitLink) || (state_q == StActive);
    assign traffic_en  = (state_q == StActive);
    assign link_up     = (state_q == StActive);
    assign fail        = (state_q == StFailed);
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_qeciphy_link_supervisor.sv
// Bench for qeciphy_link_supervisor: directed scenarios plus randomized traffic, all
// checked every cycle against an attempt/elapsed-time model of the bring-up sequence.
module tb_qeciphy_link_supervisor;

    localparam int RST  = 16;
    localparam int TO   = 8;
    localparam int MAXR = 2;

    logic       ACLK = 1'b0;
    logic       ARST = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] STATUS = 4'd0;
    logic [3:0] ECODE = 4'd0;
    logic       rx_data_error = 1'b0;
    logic       phy_arstn, traffic_en, link_up, fail;
    logic [3:0] retry_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    qeciphy_link_supervisor #(
        .RST_CYCLES    (RST),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .ACLK         (ACLK),
        .ARST         (ARST),
        .enable       (enable),
        .STATUS       (STATUS),
        .ECODE        (ECODE),
        .rx_data_error(rx_data_error),
        .phy_arstn    (phy_arstn),
        .traffic_en   (traffic_en),
        .link_up      (link_up),
        .fail         (fail),
        .retry_count  (retry_count),
        .state        (state)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a session is a run of enable=1; within it, m_t counts cycles since the current
    // attempt began (first RST cycles are the PHY reset, the rest is the link wait).
    bit m_session, m_fail, m_up;
    int m_rty, m_t;

    function automatic void model_reset();
        m_session = 0; m_fail = 0; m_up = 0; m_rty = 0; m_t = 0;
    endfunction

    function automatic void model_retry();
        m_up = 0;
        if (m_rty < MAXR) begin
            m_rty++;
            m_t = 0;
        end else begin
            m_fail = 1;
        end
    endfunction

    function automatic void model_step();
        if (!enable) model_reset();
        else if (!m_session) begin
            m_session = 1;
            m_t = 0;
        end else if (m_fail) begin
            m_fail = 1;
        end else if (m_up) begin
            if (ECODE != 0 || STATUS != 4'b0100 || rx_data_error) model_retry();
        end else if (m_t < RST) m_t++;
        else if (ECODE != 0) model_retry();
        else if (STATUS == 4'b0100) m_up = 1;
        else if (m_t - RST == TO - 1) model_retry();
        else m_t++;
    endfunction

    function automatic int exp_state();
        if (!m_session) return 0;
        if (m_fail) return 4;
        if (m_up) return 3;
        if (m_t < RST) return 1;
        return 2;
    endfunction

    task automatic check_all();
        check("state", state, exp_state());
        check("phy_arstn", phy_arstn, m_session && !m_fail && (m_up || m_t >= RST));
        check("traffic_en", traffic_en, m_session && m_up);
        check("link_up", link_up, m_session && m_up);
        check("fail", fail, m_session && m_fail);
        check("retry_count", retry_count, m_rty);
    endtask

    task automatic cycle();
        @(posedge ACLK);
        if (ARST) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    // Raises ARST between clock edges and checks the outputs before any edge occurs.
    task automatic arst_pulse();
        #3;
        ARST = 1'b1;
        #1;
        model_reset();
        check("arst_async_arstn", phy_arstn, 0);
        check("arst_async_link", link_up, 0);
        check_all();
        cycle();
        ARST = 1'b0;
    endtask

    task automatic wait_link(input string tag);
        int k = 0;
        while (!link_up && k < 60) begin
            cycle();
            k++;
        end
        check(tag, link_up, 1);
    endtask

    initial begin
        int k;
        int prof;

        repeat (3) cycle();
        check("reset_state", state, 0);
        check("reset_retry", retry_count, 0);
        ARST = 1'b0;
        repeat (3) cycle();
        check("idle_hold", state, 0);

        // Nominal bring-up; observation index i+1 is the cycle after edge i.
        enable = 1'b1;
        for (int i = 0; i < 23; i++) begin
            STATUS = (i >= 20) ? 4'b0100 : 4'd0;
            cycle();
            if (i + 1 == 16) check("nom_rst_low", phy_arstn, 0);
            if (i + 1 == 17) check("nom_arstn_rise", phy_arstn, 1);
            if (i + 1 == 20) check("nom_not_up", link_up, 0);
            if (i + 1 == 21) begin
                check("nom_link_up", link_up, 1);
                check("nom_retry", retry_count, 0);
            end
        end

        // Timeout retries until failure.
        enable = 1'b0;
        STATUS = 4'd0;
        cycle();
        enable = 1'b1;
        k = 0;
        while (!fail && k < 200) begin
            cycle();
            k++;
        end
        check("to_fail", fail, 1);
        check("to_latency", k, 3 * (RST + TO) + 1);
        check("to_retry", retry_count, MAXR);
        repeat (5) cycle();
        check("to_hold", state, 4);
        enable = 1'b0;
        cycle();
        check("to_idle", state, 0);
        check("to_retry_clr", retry_count, 0);

        // ECODE beats STATUS in WAIT_LINK.
        enable = 1'b1;
        repeat (RST + 1) cycle();
        check("pri_in_wait", state, 2);
        ECODE = 4'h3;
        STATUS = 4'b0100;
        cycle();
        ECODE = 4'd0;
        check("pri_state", state, 1);
        check("pri_retry", retry_count, 1);

        // rx_data_error in ACTIVE.
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        wait_link("err_first_up");
        rx_data_error = 1'b1;
        cycle();
        rx_data_error = 1'b0;
        check("err_traffic", traffic_en, 0);
        check("err_arstn", phy_arstn, 0);
        check("err_state", state, 1);
        wait_link("err_recover");
        check("err_retry", retry_count, 1);

        // Abort during RESET, then ARST during ACTIVE.
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        repeat (5) cycle();
        enable = 1'b0;
        cycle();
        check("abort_idle", state, 0);
        enable = 1'b1;
        wait_link("arst_pre_up");
        arst_pulse();
        cycle();
        check("arst_restart", state, 1);

        // Randomized traffic with shifting input biases.
        prof = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) prof = $urandom_range(0, 3);
            enable = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            case (prof)
                0: STATUS = ($urandom_range(0, 19) == 0) ? 4'b0100 : 4'd0;
                1: STATUS = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0100;
                2: STATUS = 4'b0100;
                default: STATUS = 4'($urandom);
            endcase
            ECODE = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            rx_data_error = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 499) == 0) arst_pulse();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/qeciphy_link_supervisor.md
QECIPHY_LINK_SUPERVISOR -- requirements
Module: qeciphy_link_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles PHY reset is held low per attempt (>=1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536: link-up wait budget per attempt (>=2).
REQ-003 SHALL have parameter MAX_RETRIES, default 7: number of re-attempts after the first before declaring failure (0..15).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: ports ACLK and ARST.
REQ-005 ACLK  input  1  sole clock; all other inputs are synchronous to it.
REQ-006 ARST  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  level request to bring the link up; deassert to stop.
REQ-008 STATUS  input  4  PHY status; 4'b0100 = link ready.
REQ-009 ECODE  input  4  PHY error code; nonzero = error.
REQ-010 rx_data_error  input  1  sticky error from the external RX data checker.
REQ-011 phy_arstn  output  1  active-low reset to the PHY and traffic logic.
REQ-012 traffic_en  output  1  permits TX traffic generation.
REQ-013 link_up  output  1  link ready and traffic running.
REQ-014 fail  output  1  retry budget exhausted.
REQ-015 retry_count  output  4  number of re-attempts made since leaving IDLE.
REQ-016 state  output  3  encoded state: IDLE=0, RESET=1, WAIT_LINK=2, ACTIVE=3, FAILED=4.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, RESET, WAIT_LINK, ACTIVE and FAILED; all outputs SHALL be decoded from registered state or counters with no combinational path from inputs.
REQ-018 phy_arstn SHALL be 1 only in WAIT_LINK and ACTIVE, and 0 in IDLE, RESET and FAILED.
REQ-019 traffic_en and link_up SHALL be 1 only in ACTIVE; fail SHALL be 1 only in FAILED.
REQ-020 enable==0 SHALL move any state to IDLE on the next edge; this transition has highest priority.
REQ-021 In IDLE, retry_count and the cycle counter SHALL be cleared; enable==1 SHALL move to RESET.
REQ-022 RESET SHALL last exactly RST_CYCLES cycles and then move to WAIT_LINK with the cycle counter cleared.
REQ-023 In WAIT_LINK, checks SHALL apply in priority order ECODE!=0, then STATUS==4'b0100, then timeout.
- ECODE!=0: retry.
- STATUS==4'b0100: move to ACTIVE.
- counter==TIMEOUT_CYCLES-1: retry, so WAIT_LINK lasts at most TIMEOUT_CYCLES cycles.
REQ-024 In ACTIVE, any of ECODE!=0, STATUS!=4'b0100 or rx_data_error==1 SHALL cause a retry; otherwise the FSM SHALL stay in ACTIVE indefinitely.
REQ-025 Retry with retry_count<MAX_RETRIES SHALL increment retry_count and move to RESET; with retry_count==MAX_RETRIES it SHALL move to FAILED with retry_count unchanged.
REQ-026 retry_count SHALL never wrap; it is bounded by MAX_RETRIES.
REQ-027 FAILED SHALL be held until enable==0, then move to IDLE; a held-high enable SHALL NOT restart the sequence.
REQ-028 Cycle counter width SHALL be clog2(max(RST_CYCLES,TIMEOUT_CYCLES))+1 bits and SHALL be cleared on every state change.

Reset
REQ-029 While ARST==1 the FSM SHALL be in IDLE, with all counters 0 and outputs phy_arstn=0, traffic_en=0, link_up=0, fail=0, retry_count=0, state=0.
REQ-030 After ARST deasserts, the first transition SHALL occur on the first ACLK rising edge at which enable==1.
REQ-031 ARST asserted mid-operation, in any state, SHALL immediately force the IDLE outputs, including phy_arstn=0 asynchronously.

Verification
REQ-032 Nominal bring-up: enable=1 at cycle 0, STATUS=0100 held from cycle 20 -> RESET for 16 cycles, phy_arstn rises at cycle 17, link_up=1 at cycle 21, retry_count=0.
REQ-033 Timeout retries: TIMEOUT_CYCLES=8, MAX_RETRIES=2, STATUS held at 0 -> three RESET/WAIT_LINK attempts, then fail=1 with retry_count=2; dropping enable -> IDLE and retry_count=0 on the next edge.
REQ-034 Priority in WAIT_LINK: ECODE=4'h3 and STATUS=0100 in the same cycle -> retry, not ACTIVE, and retry_count increments to 1.
REQ-035 Error in ACTIVE: rx_data_error pulses for 1 cycle -> traffic_en=0 and phy_arstn=0 on the next edge, state=RESET; recovery to ACTIVE on the next attempt with retry_count=1.
REQ-036 Mid-sequence abort: enable dropped during cycle 5 of RESET -> IDLE on the next edge; ARST pulse during ACTIVE -> all outputs zero immediately, with no ACLK edge required.
